// File: rtl/ov7670_sccb_sequencer_if.sv
// Pin bundle between the OV7670 startup sequencer, its command source and the SCCB pads.
interface ov7670_sccb_sequencer_if;
  logic        start;
  logic [15:0] cmd;
  logic        inc;
  logic        rom_rst_n;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;
  logic        busy;
  logic        done;

  // Sequencer side.
  modport master (
    input  start, cmd,
    output inc, rom_rst_n, sioc, siod_out, siod_oe, busy, done
  );

  // Environment side: command source, pad logic and system controller.
  modport slave (
    output start, cmd,
    input  inc, rom_rst_n, sioc, siod_out, siod_oe, busy, done
  );
endinterface

// File: rtl/ov7670_sccb_sequencer.sv
// Walks the OV7670 startup command table and plays each entry onto the SCCB bus:
// {reg,data} becomes a 3-phase write, 16'hFFF0 a fixed delay, 16'hFFFF the end.
// Output flops are loaded from the next-state values, so pins line up with the
// state register and change one clk after the cycle that ends a quarter-bit.
module ov7670_sccb_sequencer #(
  parameter logic [7:0]  CAM_ID       = 8'h42,
  parameter int unsigned QTR_CYCLES   = 62,
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int unsigned BUF_CYCLES   = 2 * QTR_CYCLES
) (
  input logic clk,
  input logic rst_n,
  ov7670_sccb_sequencer_if.master bus
);

  localparam int unsigned FRAME_W  = 27;
  localparam int unsigned BIT_W    = 5;
  localparam int unsigned QTR_W    = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam int unsigned CNT_MAX  = (DELAY_CYCLES > BUF_CYCLES) ? DELAY_CYCLES : BUF_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_LAST = FRAME_W - 1;

  localparam logic [15:0] CMD_END   = 16'hFFFF;
  localparam logic [15:0] CMD_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_START,
    S_BITS,
    S_STOP,
    S_BUSFREE,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state, state_d;
  logic [15:0]          cmd_q, cmd_q_d;
  logic [FRAME_W-1:0]   frame, frame_d;
  logic [QTR_W-1:0]     qtr_cnt, qtr_cnt_d;
  logic [1:0]           qtr_idx, qtr_idx_d;
  logic [BIT_W-1:0]     bit_idx, bit_idx_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 qtr_end;
  logic                 x_slot;

  logic inc_q, inc_d;
  logic rom_rst_n_q, rom_rst_n_d;
  logic sioc_q, sioc_d;
  logic siod_q, siod_d;
  logic oe_q, oe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // State, datapath and output registers; reset leaves the bus idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      frame       <= '0;
      qtr_cnt     <= '0;
      qtr_idx     <= '0;
      bit_idx     <= '0;
      cnt         <= '0;
      inc_q       <= 1'b0;
      rom_rst_n_q <= 1'b0;
      sioc_q      <= 1'b1;
      siod_q      <= 1'b1;
      oe_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_q_d;
      frame       <= frame_d;
      qtr_cnt     <= qtr_cnt_d;
      qtr_idx     <= qtr_idx_d;
      bit_idx     <= bit_idx_d;
      cnt         <= cnt_d;
      inc_q       <= inc_d;
      rom_rst_n_q <= rom_rst_n_d;
      sioc_q      <= sioc_d;
      siod_q      <= siod_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state sequencing and the pin values that go with the next state.
  always_comb begin
    state_d   = state;
    cmd_q_d   = cmd_q;
    frame_d   = frame;
    qtr_cnt_d = qtr_cnt;
    qtr_idx_d = qtr_idx;
    bit_idx_d = bit_idx;
    cnt_d     = cnt;
    qtr_end   = (qtr_cnt == QTR_W'(QTR_CYCLES - 1));

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      // Source output is registered: second FETCH cycle is the first with valid cmd.
      S_FETCH: begin
        if (cnt == CNT_W'(1)) begin
          cmd_q_d = bus.cmd;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        if (cmd_q == CMD_END) begin
          state_d = S_DONE;
        end else if (cmd_q == CMD_DELAY) begin
          state_d = S_DELAY;
          cnt_d   = '0;
        end else begin
          // Don't-care slots are loaded as 1 so a released line reads the same.
          frame_d   = {CAM_ID, 1'b1, cmd_q[15:8], 1'b1, cmd_q[7:0], 1'b1};
          qtr_cnt_d = '0;
          qtr_idx_d = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (qtr_end) begin
          qtr_cnt_d = '0;
          if (qtr_idx == 2'd3) begin
            qtr_idx_d = '0;
            bit_idx_d = '0;
            state_d   = S_BITS;
          end else begin
            qtr_idx_d = qtr_idx + 2'd1;
          end
        end else begin
          qtr_cnt_d = qtr_cnt + QTR_W'(1);
        end
      end

      S_BITS: begin
        if (qtr_end) begin
          qtr_cnt_d = '0;
          if (qtr_idx == 2'd3) begin
            qtr_idx_d = '0;
            if (bit_idx == BIT_W'(BIT_LAST)) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx + BIT_W'(1);
              frame_d   = {frame[FRAME_W-2:0], 1'b1};
            end
          end else begin
            qtr_idx_d = qtr_idx + 2'd1;
          end
        end else begin
          qtr_cnt_d = qtr_cnt + QTR_W'(1);
        end
      end

      S_STOP: begin
        if (qtr_end) begin
          qtr_cnt_d = '0;
          if (qtr_idx == 2'd2) begin
            cnt_d   = '0;
            state_d = S_BUSFREE;
          end else begin
            qtr_idx_d = qtr_idx + 2'd1;
          end
        end else begin
          qtr_cnt_d = qtr_cnt + QTR_W'(1);
        end
      end

      S_BUSFREE: begin
        if (cnt == CNT_W'(BUF_CYCLES - 1)) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DELAY: begin
        if (cnt == CNT_W'(DELAY_CYCLES - 1)) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_NEXT: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    x_slot = (bit_idx_d == BIT_W'(8)) || (bit_idx_d == BIT_W'(17)) ||
             (bit_idx_d == BIT_W'(26));

    inc_d       = 1'b0;
    rom_rst_n_d = 1'b1;
    sioc_d      = 1'b1;
    siod_d      = 1'b1;
    oe_d        = 1'b1;
    busy_d      = 1'b1;
    done_d      = 1'b0;

    case (state_d)
      S_IDLE: begin
        rom_rst_n_d = 1'b0;
        busy_d      = 1'b0;
      end
      S_DONE: begin
        rom_rst_n_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end
      S_NEXT: inc_d = 1'b1;
      S_START: begin
        case (qtr_idx_d)
          2'd0:    ;
          2'd1:    siod_d = 1'b0;
          default: begin
            sioc_d = 1'b0;
            siod_d = 1'b0;
          end
        endcase
      end
      S_BITS: begin
        sioc_d = qtr_idx_d[1];
        siod_d = frame_d[FRAME_W-1];
        oe_d   = ~x_slot;
      end
      S_STOP: begin
        case (qtr_idx_d)
          2'd0: begin
            sioc_d = 1'b0;
            siod_d = 1'b0;
          end
          2'd1:    siod_d = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.inc       = inc_q;
  assign bus.rom_rst_n = rom_rst_n_q;
  assign bus.sioc      = sioc_q;
  assign bus.siod_out  = siod_q;
  assign bus.siod_oe   = oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ov7670_sccb_sequencer.sv
// Directed bench for ov7670_sccb_sequencer with a registered command ROM and an SCCB frame decoder.
module tb_ov7670_sccb_sequencer;

  localparam int unsigned QTR = 2;
  localparam int unsigned DLY = 100;
  localparam int unsigned BUF = 4;
  // First FETCH cycle to inc of a write entry: 2 FETCH + 1 DECODE + 115 quarters + bus-free.
  localparam int WR_INC   = 2 + 1 + 115 * QTR + BUF;
  // First FETCH cycle to inc of a delay entry.
  localparam int DLY_INC  = 2 + 1 + DLY;
  // inc, 2 FETCH, 1 DECODE, then DONE.
  localparam int TAIL     = 4;

  localparam logic [15:0] FULL [0:74] = '{
    16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C00, 16'h0400,
    16'h4010, 16'h3A04, 16'h1438, 16'h4F40, 16'h5034, 16'h510C, 16'h5217, 16'h5329,
    16'h5440, 16'h581E, 16'h3DC0, 16'h1100, 16'h1711, 16'h1861, 16'h32A4, 16'h1903,
    16'h1A7B, 16'h030A, 16'h0E61, 16'h0F4B, 16'h1602, 16'h1E37, 16'h2102, 16'h2291,
    16'h2907, 16'h330B, 16'h350B, 16'h371D, 16'h3871, 16'h392A, 16'h3C78, 16'h4D40,
    16'h4E20, 16'h6900, 16'h6B4A, 16'h7410, 16'h8D4F, 16'h8E00, 16'h8F00, 16'h9000,
    16'h9100, 16'h9600, 16'h9A00, 16'hB084, 16'hB10C, 16'hB20E, 16'hB382, 16'hB80A,
    16'hFF00, 16'h1300, 16'h0100, 16'h0200, 16'h0D40, 16'h1418, 16'h2495, 16'h2533,
    16'h26E3, 16'hA005, 16'hA105, 16'hA618, 16'hA8C1, 16'hA954, 16'hAA40, 16'h13E0,
    16'h7B10, 16'h13E5, 16'hFFFF
  };

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ov7670_sccb_sequencer_if bus ();

  ov7670_sccb_sequencer #(
    .CAM_ID      (8'h42),
    .QTR_CYCLES  (QTR),
    .DELAY_CYCLES(DLY),
    .BUF_CYCLES  (BUF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used as a timing reference.
  always @(posedge clk) cyc <= cyc + 1;

  // Command source: address held at 0 in rewind, advanced by inc, data registered once more.
  logic [15:0] rom [0:127];
  logic [6:0]  rom_addr;
  always @(posedge clk) begin
    if (!bus.rom_rst_n) rom_addr <= '0;
    else if (bus.inc)   rom_addr <= rom_addr + 7'd1;
    bus.cmd <= rom[rom_addr];
  end

  // Bus monitor: decodes START/STOP, samples siod on sioc rising edges, counts inc pulses.
  logic        prev_sioc = 1'b1, prev_siod = 1'b1, prev_inc = 1'b0;
  logic        in_frame = 1'b0;
  logic        slot_m;
  int          bit_cnt = 0, oe_bad = 0, oe_low = 0;
  int          sioc_toggles = 0, inc_rise = 0, inc_high = 0, last_inc_cyc = 0;
  logic [26:0] shreg;
  logic [24:0] frames [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (bus.sioc !== prev_sioc) sioc_toggles++;
      if (bus.inc) begin
        inc_high++;
        last_inc_cyc = cyc;
        if (!prev_inc) inc_rise++;
      end
      if (bus.sioc && prev_sioc && prev_siod && !bus.siod_out && bus.siod_oe) begin
        in_frame = 1'b1;
        bit_cnt  = 0;
        shreg    = '0;
        oe_bad   = 0;
        oe_low   = 0;
      end else if (in_frame && bus.sioc && !prev_sioc) begin
        if (bit_cnt < 27) begin
          shreg  = {shreg[25:0], bus.siod_out};
          slot_m = (bit_cnt == 8) || (bit_cnt == 17) || (bit_cnt == 26);
          if (bus.siod_oe === slot_m) oe_bad++;
          if (!bus.siod_oe) oe_low++;
        end
        bit_cnt++;
      end else if (in_frame && bus.sioc && prev_sioc && !prev_siod && bus.siod_out) begin
        // 27 data edges plus the STOP rising edge.
        frames.push_back({(bit_cnt == 28) && (oe_bad == 0) && (oe_low == 3),
                          shreg[26:19], shreg[17:10], shreg[8:1]});
        in_frame = 1'b0;
      end
    end
    prev_sioc = bus.sioc;
    prev_siod = bus.siod_out;
    prev_inc  = bus.inc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input int which);
    for (int i = 0; i < 128; i++) rom[i] = 16'hFFFF;
    case (which)
      0: rom[0] = 16'h1204;
      1: rom[0] = 16'hFFF0;
      default: for (int i = 0; i < 75; i++) rom[i] = FULL[i];
    endcase
  endtask

  task automatic pulse_start(output int c0);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; c0 = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int c_done);
    ok = 1'b0;
    c_done = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        c_done = cyc;
      end
    end
  endtask

  task automatic wait_in_frame(input int nframes, input int min_bit, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (frames.size() == nframes && in_frame && bit_cnt >= min_bit && bit_cnt < 20) ok = 1'b1;
    end
  endtask

  initial begin
    int c0, cd, fb, ib, ih, tb, errs, k;
    bit ok;

    rst_n = 1'b0;
    bus.start = 1'b0;
    load_rom(0);
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_inc",       32'(bus.inc),       32'd0);
    check("rst_rom_rst_n", 32'(bus.rom_rst_n), 32'd0);
    check("rst_bus",       32'({bus.sioc, bus.siod_out, bus.siod_oe}), 32'h7);
    check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rom_rst_n", 32'(bus.rom_rst_n), 32'd0);

    // Single write 0x1204 with a second start pulse inside the frame.
    fb = frames.size(); ib = inc_rise; ih = inc_high;
    pulse_start(c0);
    check("sw_start_accept", 32'({bus.busy, bus.done, bus.rom_rst_n}), 32'b101);
    wait_in_frame(fb, 10, 2000, ok);
    check("sw_reach_bits", 32'(ok), 32'd1);
    pulse_start(k);
    check("sw_busy_after_2nd_start", 32'(bus.busy), 32'd1);
    wait_done(3000, ok, cd);
    check("sw_done_seen", 32'(ok), 32'd1);
    check("sw_frame_count", 32'(frames.size() - fb), 32'd1);
    if (frames.size() > fb) check("sw_frame", 32'(frames[fb]), {7'd0, 1'b1, 8'h42, 16'h1204});
    check("sw_inc_count", 32'(inc_rise - ib), 32'd1);
    check("sw_inc_single", 32'(inc_high - ih), 32'd1);
    check("sw_inc_time", 32'(last_inc_cyc - c0), 32'(WR_INC));
    check("sw_done_time", 32'(cd - c0), 32'(WR_INC + TAIL));
    check("sw_done_pins", 32'({bus.done, bus.busy, bus.rom_rst_n}), 32'b100);

    // Delay entry, started from DONE.
    load_rom(1);
    @(negedge clk);
    fb = frames.size(); ib = inc_rise; tb = sioc_toggles;
    pulse_start(c0);
    check("dly_restart_pins", 32'({bus.busy, bus.done, bus.rom_rst_n}), 32'b101);
    wait_done(1000, ok, cd);
    check("dly_done_seen", 32'(ok), 32'd1);
    check("dly_no_sioc", 32'(sioc_toggles - tb), 32'd0);
    check("dly_no_frames", 32'(frames.size() - fb), 32'd0);
    check("dly_inc_count", 32'(inc_rise - ib), 32'd1);
    check("dly_inc_time", 32'(last_inc_cyc - c0), 32'(DLY_INC));
    check("dly_done_time", 32'(cd - c0), 32'(DLY_INC + TAIL));

    // Full table, reset during the 2nd SCCB frame (command index 2).
    load_rom(2);
    @(negedge clk);
    fb = frames.size();
    pulse_start(c0);
    wait_in_frame(fb + 1, 5, 3000, ok);
    check("mid_reach_bits", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bus", 32'({bus.sioc, bus.siod_out, bus.siod_oe}), 32'h7);
    check("mid_rst_ctl", 32'({bus.busy, bus.rom_rst_n, bus.inc, bus.done}), 32'd0);
    if (frames.size() > fb) check("mid_first_frame", 32'(frames[fb]), {7'd0, 1'b1, 8'h42, 16'h1280});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full table from reset: must replay from entry 0.
    fb = frames.size(); ib = inc_rise; ih = inc_high;
    pulse_start(c0);
    wait_done(40000, ok, cd);
    check("full_done_seen", 32'(ok), 32'd1);
    check("full_inc_count", 32'(inc_rise - ib), 32'd74);
    check("full_inc_single", 32'(inc_high - ih), 32'd74);
    check("full_frame_count", 32'(frames.size() - fb), 32'd73);
    if (frames.size() > fb) check("full_first", 32'(frames[fb]), {7'd0, 1'b1, 8'h42, 16'h1280});
    if (frames.size() > 0) check("full_last", 32'(frames[frames.size() - 1]), {7'd0, 1'b1, 8'h42, 16'h13E5});
    errs = 0;
    k = fb;
    for (int i = 0; i < 75; i++) begin
      if (FULL[i] != 16'hFFF0 && FULL[i] != 16'hFFFF) begin
        if (k >= frames.size() || frames[k] !== {1'b1, 8'h42, FULL[i]}) errs++;
        k++;
      end
    end
    check("full_order_errs", 32'(errs), 32'd0);
    check("full_done_pins", 32'({bus.done, bus.busy, bus.rom_rst_n}), 32'b100);

    // Rerun of the single write from DONE must be identical.
    load_rom(0);
    @(negedge clk);
    fb = frames.size(); ib = inc_rise;
    pulse_start(c0);
    check("rr_restart_pins", 32'({bus.busy, bus.done, bus.rom_rst_n}), 32'b101);
    wait_done(3000, ok, cd);
    check("rr_done_seen", 32'(ok), 32'd1);
    check("rr_frame_count", 32'(frames.size() - fb), 32'd1);
    if (frames.size() > fb) check("rr_frame", 32'(frames[fb]), {7'd0, 1'b1, 8'h42, 16'h1204});
    check("rr_inc_count", 32'(inc_rise - ib), 32'd1);
    check("rr_done_time", 32'(cd - c0), 32'(WR_INC + TAIL));

    // DONE holds without start.
    repeat (5) @(negedge clk);
    check("done_hold", 32'({bus.done, bus.busy}), 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_sccb_sequencer.md
Name: ov7670_sccb_sequencer

Overview:
- Consumes the 16-bit camera startup command stream and executes it on the OV7670 SCCB bus.
- Each command is one of:
  - {reg,data}: a 3-phase SCCB write.
  - 16'hFFF0: a delay.
  - 16'hFFFF: end of table.
- Drives the command source's `inc` and `rst_n` (rewind) inputs, so a single `start` pulse configures the whole camera and reports `done`.

Parameters:
- CAM_ID, 8'h42, SCCB write ID byte (phase 1).
- QTR_CYCLES, 62, clk cycles per SCCB quarter-bit (25 MHz clk, ~100 kHz SIOC).
- DELAY_CYCLES, 250000, clk cycles executed for a 16'hFFF0 command (10 ms at 25 MHz).
- BUF_CYCLES, 2*QTR_CYCLES, bus-free time after each stop condition.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; all flops clear immediately on assertion.
- start  in  1  begin configuration; sampled only in IDLE.
- cmd  in  16  current command from the command source; valid 2 clk cycles after an `inc` pulse or after rewind release.
- inc  out  1  single-cycle pulse that advances the command source.
- rom_rst_n  out  1  low while IDLE/DONE so the command source is held at address 0.
- sioc  out  1  SCCB clock, idles high.
- siod_out  out  1  SCCB data value.
- siod_oe  out  1  1 = drive `siod_out`; 0 = release (top level tristates, pull-up gives 1).
- busy  out  1  high from accepted start until DONE.
- done  out  1  high in DONE, held until `start` or reset.

Behaviour:
- Reset values:
  - inc=0, rom_rst_n=0, sioc=1, siod_out=1, siod_oe=1, busy=0, done=0.
  - State IDLE, all counters 0.
- States: IDLE, FETCH, DECODE, START, BITS, STOP, BUSFREE, DELAY, NEXT, DONE.
- IDLE:
  - rom_rst_n=0.
  - `start`=1 → FETCH, busy=1, done=0, rom_rst_n=1.
  - `start` is ignored in every other state except DONE.
- FETCH: wait exactly 2 clk cycles (source registered latency), then latch `cmd` into cmd_q → DECODE.
- DECODE:
  - cmd_q==16'hFFFF → DONE.
  - cmd_q==16'hFFF0 → DELAY.
  - Otherwise load the 27-bit shift frame {CAM_ID,X, cmd_q[15:8],X, cmd_q[7:0],X} → START.
  - X = don't-care slot.
- Quarter-bit timer: counts 0..QTR_CYCLES-1; each wrap is one quarter.
- START (4 quarters), sioc/siod per quarter: q0 1/1, q1 1/0, q2 0/0, q3 0/0 → BITS.
- BITS: 27 bits, MSB first, 4 quarters each.
  - q0: sioc=0, `siod` updated.
  - q1: sioc=0.
  - q2, q3: sioc=1.
  - Data bit: siod_oe=1.
  - X slot (bits 8, 17, 26): siod_oe=0 for all 4 quarters. The ACK is not sampled (write-only master).
  - After bit 26 → STOP.
- STOP (3 quarters): q0 sioc=0, siod=0, oe=1; q1 sioc=1, siod=0; q2 sioc=1, siod=1 → BUSFREE.
- BUSFREE: sioc=1, siod=1 for BUF_CYCLES → NEXT.
- DELAY: bus idle (sioc=1, siod=1, oe=1) for exactly DELAY_CYCLES cycles → NEXT.
- NEXT: `inc`=1 for exactly one cycle → FETCH.
- DONE:
  - busy=0, done=1, rom_rst_n=0, bus idle.
  - `start`=1 → restarts as from IDLE; done clears that cycle.
- Timing:
  - One register write = (4+108+3) quarters + BUF_CYCLES ≈ 115*QTR_CYCLES + BUF_CYCLES clk.
  - Outputs are registered; pin changes occur 1 clk after the quarter boundary.
- Boundary and exception rules:
  - Reset mid-transfer: all outputs immediately return to reset values, aborting the SCCB frame. The bus is left idle-high (camera recovers on next start).
  - `start` while busy: ignored, no effect on the sequence.
  - `start` and end-of-table in the same cycle: DONE is entered first; start is honoured on a later cycle.
  - A command other than FFF0/FFFF whose high byte is 8'hFF is treated as a write.
  - Timer and counters never wrap past their terminal values; each state resets its counter on entry.

Test Plan:
- Single write: bench ROM {16'h1204, 16'hFFFF}, start pulse. Required:
  - START waveform present.
  - siod sampled on sioc rising edges = 0x42, 0x12, 0x04 MSB first.
  - siod_oe=0 during the 3 X slots.
  - STOP waveform present.
  - One `inc` pulse, then done=1, busy=0.
- Delay: ROM {16'hFFF0, 16'hFFFF} with DELAY_CYCLES=100. Required:
  - No sioc toggles.
  - `inc` occurs 100 cycles (±fixed FETCH/DECODE overhead, as documented) after the DECODE cycle.
  - done asserts.
- Full 75-entry startup table with QTR_CYCLES=2 and a reduced delay. Required:
  - Exactly 74 `inc` pulses.
  - 73 SCCB frames decoded in order, starting 0x1280 and ending 0x13e5.
  - done=1.
- Reset mid-frame: deassert rst_n during BITS of the 3rd command. Required:
  - Same cycle: sioc=1, siod_out=1, oe=1, busy=0, rom_rst_n=0.
  - Restart after reset replays from command 0 (0x1280).
- Start handling:
  - Second start pulse during a frame → no restart; frame bytes unchanged.
  - Start pulse in DONE → rom_rst_n=1 and the sequence reruns identically.
- Fetch latency: bench ROM with 1-cycle registered output. Verify cmd_q is latched 2 cycles after each `inc`, never capturing the previous entry.
